// File: rtl/times_table_pkg.sv
// Shared types and helpers for the times-table writer: FSM states, default
// operand widths and the end-of-table address detect.
package times_table_pkg;

  localparam int TT_A_W = 3;
  localparam int TT_B_W = 3;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    FLUSH,
    DONE
  } tt_state_e;

  // True when {a,b} is the all-ones address, i.e. the final table entry.
  function automatic logic tt_last(input int a, input int b, input int a_w, input int b_w);
    return (a == (1 << a_w) - 1) && (b == (1 << b_w) - 1);
  endfunction

endpackage

// File: rtl/tt_seq_gen.sv
// Walks {a,b} over the whole table in row-major order and keeps acc = a*b
// by repeated addition of a along each row.
module tt_seq_gen
  import times_table_pkg::*;
#(
  parameter  int A_W    = TT_A_W,
  parameter  int B_W    = TT_B_W,
  localparam int ADDR_W = A_W + B_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              step,
  output logic [A_W-1:0]    a,
  output logic [B_W-1:0]    b,
  output logic [ADDR_W-1:0] acc,
  output logic              last
);

  logic [A_W-1:0]    a_q, a_d;
  logic [B_W-1:0]    b_q, b_d;
  logic [ADDR_W-1:0] acc_q, acc_d;

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    if (clr) begin
      a_d   = '0;
      b_d   = '0;
      acc_d = '0;
    end else if (step) begin
      // End of a row: restart the product at a*0 for the next row.
      if (b_q == '1) begin
        b_d   = '0;
        acc_d = '0;
        a_d   = a_q + 1'b1;
      end else begin
        b_d   = b_q + 1'b1;
        acc_d = acc_q + ADDR_W'(a_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
    end
  end

  assign a    = a_q;
  assign b    = b_q;
  assign acc  = acc_q;
  assign last = tt_last(int'(a_q), int'(b_q), A_W, B_W);

endmodule

// File: rtl/times_table_writer.sv
// Loads the A x B times table into a single-port RAM at address {a,b}, then
// reads every entry back and flags the first mismatching address.
module times_table_writer
  import times_table_pkg::*;
#(
  parameter  int A_W    = TT_A_W,
  parameter  int B_W    = TT_B_W,
  localparam int ADDR_W = A_W + B_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] err_addr,
  output logic              ena,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [ADDR_W-1:0] dina,
  input  logic [ADDR_W-1:0] douta
);

  tt_state_e state_q, state_d;

  logic              seq_clr, seq_step, seq_last;
  logic [A_W-1:0]    seq_a;
  logic [B_W-1:0]    seq_b;
  logic [ADDR_W-1:0] seq_acc;

  logic              chk_vld_q, chk_vld_d;
  logic [ADDR_W-1:0] exp_q, exp_d;
  logic [ADDR_W-1:0] chk_addr_q, chk_addr_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;

  tt_seq_gen #(.A_W(A_W), .B_W(B_W)) u_seq (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (seq_clr),
    .step  (seq_step),
    .a     (seq_a),
    .b     (seq_b),
    .acc   (seq_acc),
    .last  (seq_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    seq_clr  = 1'b0;
    seq_step = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = WRITE;
        seq_clr = 1'b1;
      end
      WRITE: if (seq_last) begin
        state_d = READ;
        seq_clr = 1'b1;
      end else begin
        seq_step = 1'b1;
      end
      READ: begin
        seq_step = 1'b1;
        if (seq_last) state_d = FLUSH;
      end
      FLUSH:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy  = 1'b0;
    done  = 1'b0;
    ena   = 1'b0;
    wea   = 1'b0;
    addra = '0;
    dina  = '0;
    case (state_q)
      WRITE: begin
        busy  = 1'b1;
        ena   = 1'b1;
        wea   = 1'b1;
        addra = {seq_a, seq_b};
        dina  = seq_acc;
      end
      READ: begin
        busy  = 1'b1;
        ena   = 1'b1;
        addra = {seq_a, seq_b};
      end
      FLUSH:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Expected value and address trail the read issue by one cycle to meet douta.
  always_comb begin
    chk_vld_d  = (state_q == READ);
    exp_d      = seq_acc;
    chk_addr_d = {seq_a, seq_b};
    err_d      = err_q;
    err_addr_d = err_addr_q;
    if (state_q == IDLE && start) begin
      err_d      = 1'b0;
      err_addr_d = '0;
    end else if (chk_vld_q && douta != exp_q) begin
      err_d = 1'b1;
      if (!err_q) err_addr_d = chk_addr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_vld_q  <= 1'b0;
      exp_q      <= '0;
      chk_addr_q <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      chk_vld_q  <= chk_vld_d;
      exp_q      <= exp_d;
      chk_addr_q <= chk_addr_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign err      = err_q;
  assign err_addr = err_addr_q;

endmodule

// File: tb/tb_times_table_writer.sv
// Bench for times_table_writer: behavioural 64x6 RAM with 1-cycle read latency,
// optional bit0 corruption on chosen read addresses, and a done-event scoreboard.
module tb_times_table_writer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       busy, done, err, ena, wea;
  logic [5:0] err_addr, addra, dina, douta;

  always #5 clk = ~clk;

  times_table_writer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .err_addr (err_addr),
    .ena      (ena),
    .wea      (wea),
    .addra    (addra),
    .dina     (dina),
    .douta    (douta)
  );

  logic [5:0] ram [64];
  logic [5:0] rd_q;
  logic [5:0] rd_a_q;
  logic       inj_en = 1'b0;
  logic [5:0] inj_a0 = 6'o23;
  logic [5:0] inj_a1 = 6'o44;

  always @(posedge clk) begin
    if (ena) begin
      if (wea) ram[addra] <= dina;
      else begin
        rd_q   <= ram[addra];
        rd_a_q <= addra;
      end
    end
  end

  assign douta = rd_q ^ {5'b0, inj_en && (rd_a_q == inj_a0 || rd_a_q == inj_a1)};

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  typedef struct {
    int         cyc;
    logic       err;
    logic [5:0] addr;
  } exp_t;
  exp_t sb[$];

  // Cycle label at a negedge is cyc+1 (the cycle after the edge just taken).
  always @(negedge clk) begin
    if (rst_n && done === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL done_unexpected: cycle=%0d required=no done", cyc + 1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (cyc + 1 != e.cyc || err !== e.err || err_addr !== e.addr) begin
          bad++;
          $display("FAIL done_event: cycle=%0d err=%b err_addr=%0o required cycle=%0d err=%b err_addr=%0o",
                   cyc + 1, err, err_addr, e.cyc, e.err, e.addr);
        end
      end
    end
  end

  task automatic pulse_start(output int t0);
    @(negedge clk);
    start = 1'b1;
    t0 = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    total++;
    if ({ena, wea, busy, done, err, err_addr, addra, dina} !== '0) begin
      bad++;
      $display("FAIL reset_held: outputs=%h required=0", {ena, wea, busy, done, err, err_addr, addra, dina});
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      total++;
      if ({ena, wea, busy, done, err} !== 5'b0) begin
        bad++;
        $display("FAIL reset_idle cycle %0d: ena/wea/busy/done/err=%b required=00000", i, {ena, wea, busy, done, err});
      end
    end
    total++;
    if (err_addr !== 6'd0) begin
      bad++;
      $display("FAIL reset_err_addr: got=%0o required=0", err_addr);
    end
  endtask

  task automatic test_basic;
    int t0, busy_bad, ram_bad;
    busy_bad = 0;
    ram_bad = 0;
    pulse_start(t0);
    sb.push_back('{t0 + 130, 1'b0, 6'd0});
    for (int l = t0 + 1; l <= t0 + 131; l++) begin
      if (busy !== (l <= t0 + 129)) busy_bad++;
      if (l < t0 + 131) @(negedge clk);
    end
    total++;
    if (busy_bad != 0) begin
      bad++;
      $display("FAIL basic_busy_window: wrong_cycles=%0d required=0", busy_bad);
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL basic_done_seen: pending=%0d required=0", sb.size());
      sb.delete();
    end
    total++;
    if (ram[6'o35] !== 6'd15) begin
      bad++;
      $display("FAIL basic_ram_3x5: got=%0d required=15", ram[6'o35]);
    end
    total++;
    if (ram[6'o77] !== 6'd49) begin
      bad++;
      $display("FAIL basic_ram_7x7: got=%0d required=49", ram[6'o77]);
    end
    total++;
    if (ram[6'o06] !== 6'd0) begin
      bad++;
      $display("FAIL basic_ram_0x6: got=%0d required=0", ram[6'o06]);
    end
    for (int a = 0; a < 8; a++)
      for (int b = 0; b < 8; b++)
        if (ram[a*8+b] !== 6'(a*b)) ram_bad++;
    total++;
    if (ram_bad != 0) begin
      bad++;
      $display("FAIL basic_ram_all: wrong_entries=%0d required=0", ram_bad);
    end
  endtask

  task automatic test_err_inject;
    int t0;
    inj_a0 = 6'o23;
    inj_a1 = 6'o44;
    inj_en = 1'b1;
    pulse_start(t0);
    sb.push_back('{t0 + 130, 1'b1, 6'o23});
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL inject_drain: pending=%0d required=0", sb.size());
      sb.delete();
    end
    inj_en = 1'b0;
    @(negedge clk);
    total++;
    if (err !== 1'b1 || err_addr !== 6'o23) begin
      bad++;
      $display("FAIL inject_sticky: err=%b err_addr=%0o required err=1 err_addr=23", err, err_addr);
    end
  endtask

  task automatic test_reset_mid;
    int t0, ram_bad;
    ram_bad = 0;
    pulse_start(t0);
    repeat (39) @(negedge clk);
    total++;
    if (wea !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL midreset_pre: wea=%b busy=%b required 1 1", wea, busy);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({ena, wea, busy, done, err, err_addr, addra, dina} !== '0) begin
      bad++;
      $display("FAIL midreset_outputs: got=%h required=0", {ena, wea, busy, done, err, err_addr, addra, dina});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({ena, busy, err} !== 3'b0) begin
      bad++;
      $display("FAIL midreset_idle: ena/busy/err=%b required=000", {ena, busy, err});
    end
    pulse_start(t0);
    sb.push_back('{t0 + 130, 1'b0, 6'd0});
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL midreset_drain: pending=%0d required=0", sb.size());
      sb.delete();
    end
    for (int a = 0; a < 8; a++)
      for (int b = 0; b < 8; b++)
        if (ram[a*8+b] !== 6'(a*b)) ram_bad++;
    total++;
    if (ram_bad != 0) begin
      bad++;
      $display("FAIL midreset_ram: wrong_entries=%0d required=0", ram_bad);
    end
  endtask

  task automatic test_ignore_busy;
    int t0;
    pulse_start(t0);
    sb.push_back('{t0 + 130, 1'b0, 6'd0});
    repeat (9) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (118) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    total++;
    if (sb.size() != 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL ignore_busy: pending=%0d busy=%b required pending=0 busy=0", sb.size(), busy);
      sb.delete();
    end
  endtask

  task automatic test_back_to_back;
    int t0;
    inj_a0 = 6'o23;
    inj_a1 = 6'o23;
    inj_en = 1'b1;
    @(negedge clk);
    start = 1'b1;
    t0 = cyc + 1;
    sb.push_back('{t0 + 130, 1'b1, 6'o23});
    sb.push_back('{t0 + 261, 1'b0, 6'd0});
    sb.push_back('{t0 + 392, 1'b0, 6'd0});
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (cyc == t0 + 129) inj_en = 1'b0;
      if (cyc == t0 + 131) begin
        total++;
        if (err !== 1'b0 || err_addr !== 6'd0 || busy !== 1'b1) begin
          bad++;
          $display("FAIL b2b_err_clear: err=%b err_addr=%0o busy=%b required 0 0 1", err, err_addr, busy);
        end
      end
    end
    start = 1'b0;
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL b2b_drain: pending=%0d required=0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_err_inject();
    test_reset_mid();
    test_ignore_busy();
    test_back_to_back();
    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
